// File: rtl/draw_ball_ctl_if.sv
`timescale 1ns / 1ps
// vga_if: VGA timing + colour bundle passed between drawing stages.
//   vcount, hcount : pixel counters (11 bit)
//   vsync, hsync   : sync pulses
//   vblnk, hblnk   : blanking flags
//   rgb            : 12-bit colour (4:4:4)
// Modport 'in' is the consumer view and 'out' the producer view.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_ball_ctl.sv
`timescale 1ns / 1ps
// draw_ball_ctl: ball game logic and ball overlay for the single-player
// screen. Sits after the racket stage in the 1024x768 @ 65 MHz pipeline.
// Game state advances once per frame on the rising edge of vblnk; the
// stream itself is delayed by one clock with the ball square painted on.
//
// Ports:
//   clk65MHz      in   pixel clock
//   rst           in   synchronous active-high reset
//   mouse_ypos    in   requested player-1 racket top (unclamped)
//   screen_idle   in   menu screen active
//   screen_single in   single-player screen active
//   draw_rect_if  in   stream from the racket stage
//   draw_ball_if  out  stream with ball overlay, 1 clock latency
//   point_p1      out  1-clock pulse, player 1 scored
//   point_p2      out  1-clock pulse, player 2 scored
//   ball_active   out  high while serving or moving
module draw_ball_ctl #(
    parameter logic [11:0] X_P1         = 12'd20,
    parameter logic [11:0] X_P2         = 12'd990,
    parameter logic [11:0] RACKET_W     = 12'd14,
    parameter logic [11:0] BALL_SIZE    = 12'd12,
    parameter logic [11:0] BALL_SPEED   = 12'd4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter logic [11:0] BALL_RGB     = 12'hf_f_0
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic [11:0] mouse_ypos,
    input  logic        screen_idle,
    input  logic        screen_single,
    vga_if.in           draw_rect_if,
    vga_if.out          draw_ball_if,
    output logic        point_p1,
    output logic        point_p2,
    output logic        ball_active
);

    localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic [11:0] X_CENTRE   = 12'd506;
    localparam logic [11:0] Y_CENTRE   = 12'd378;
    localparam logic [11:0] Y_WALL_TOP = 12'd51;
    localparam logic [11:0] Y_WALL_BOT = 12'd717;
    localparam logic [11:0] T_MIN      = 12'd51;
    localparam logic [11:0] T_MAX      = 12'd637;
    localparam logic [11:0] T_SUM      = 12'd688;
    localparam logic [11:0] RACKET_H   = 12'd80;
    localparam logic [11:0] X_MAX      = 12'd1023;

    typedef enum logic [1:0] {IDLE, SERVE, MOVE} state_t;

    state_t             state, state_nxt;
    logic [11:0]        bx, bx_nxt;
    logic [11:0]        by, by_nxt;
    logic               dir_x, dir_x_nxt;   // 1 = right
    logic               dir_y, dir_y_nxt;   // 1 = down
    logic [CNT_W-1:0]   serve_cnt, serve_cnt_nxt;
    logic               point_p1_nxt, point_p2_nxt;
    logic               vblnk_d;
    logic               frame_tick;
    logic               abort;
    logic [11:0]        t1, t2;
    logic               ov1, ov2;
    logic [11:0]        hpos, vpos;
    logic               in_ball;

    assign frame_tick  = draw_rect_if.vblnk & ~vblnk_d;
    assign abort       = screen_idle | ~screen_single;
    assign ball_active = (state == SERVE) || (state == MOVE);

    // Racket spans mirror the racket stage: player 2 tracks player 1
    // reflected about the playfield centre.
    always_comb begin
        if (mouse_ypos < T_MIN)
            t1 = T_MIN;
        else if (mouse_ypos > T_MAX)
            t1 = T_MAX;
        else
            t1 = mouse_ypos;
        t2  = T_SUM - t1;
        ov1 = (by + BALL_SIZE > t1) && (by < t1 + RACKET_H);
        ov2 = (by + BALL_SIZE > t2) && (by < t2 + RACKET_H);
    end

    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt     = state;
        bx_nxt        = bx;
        by_nxt        = by;
        dir_x_nxt     = dir_x;
        dir_y_nxt     = dir_y;
        serve_cnt_nxt = serve_cnt;
        point_p1_nxt  = 1'b0;
        point_p2_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                bx_nxt        = X_CENTRE;
                by_nxt        = Y_CENTRE;
                dir_x_nxt     = 1'b1;
                dir_y_nxt     = 1'b1;
                serve_cnt_nxt = '0;
                state_nxt     = SERVE;
            end
            SERVE: begin
                if (frame_tick) begin
                    serve_cnt_nxt = serve_cnt + CNT_W'(1);
                    if (serve_cnt_nxt == SERVE_LAST) begin
                        serve_cnt_nxt = '0;
                        state_nxt     = MOVE;
                    end
                end
            end
            MOVE: begin
                if (frame_tick) begin
                    // Vertical: all tests compare before subtracting so
                    // the 12-bit position never wraps.
                    if (!dir_y) begin
                        if (by <= Y_WALL_TOP + BALL_SPEED) begin
                            by_nxt    = Y_WALL_TOP + 12'd1;
                            dir_y_nxt = 1'b1;
                        end else begin
                            by_nxt = by - BALL_SPEED;
                        end
                    end else begin
                        if (by + BALL_SIZE + BALL_SPEED >= Y_WALL_BOT) begin
                            by_nxt    = Y_WALL_BOT - 12'd1 - BALL_SIZE;
                            dir_y_nxt = 1'b0;
                        end else begin
                            by_nxt = by + BALL_SPEED;
                        end
                    end

                    // Horizontal: racket first, then goal line. A point
                    // re-centres the ball, overriding the vertical step.
                    if (!dir_x) begin
                        if (bx <= X_P1 + RACKET_W + BALL_SPEED && bx >= X_P1 && ov1) begin
                            bx_nxt    = X_P1 + RACKET_W + 12'd1;
                            dir_x_nxt = 1'b1;
                        end else if (bx < BALL_SPEED) begin
                            point_p2_nxt  = 1'b1;
                            bx_nxt        = X_CENTRE;
                            by_nxt        = Y_CENTRE;
                            dir_x_nxt     = 1'b0;
                            serve_cnt_nxt = '0;
                            state_nxt     = SERVE;
                        end else begin
                            bx_nxt = bx - BALL_SPEED;
                        end
                    end else begin
                        if (bx + BALL_SIZE + BALL_SPEED >= X_P2 &&
                            bx + BALL_SIZE <= X_P2 + RACKET_W && ov2) begin
                            bx_nxt    = X_P2 - BALL_SIZE - 12'd1;
                            dir_x_nxt = 1'b0;
                        end else if (bx + BALL_SIZE + BALL_SPEED > X_MAX) begin
                            point_p1_nxt  = 1'b1;
                            bx_nxt        = X_CENTRE;
                            by_nxt        = Y_CENTRE;
                            dir_x_nxt     = 1'b1;
                            serve_cnt_nxt = '0;
                            state_nxt     = SERVE;
                        end else begin
                            bx_nxt = bx + BALL_SPEED;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Leaving the game screen drops the ball at once, with no score.
        if (abort) begin
            state_nxt     = IDLE;
            bx_nxt        = X_CENTRE;
            by_nxt        = Y_CENTRE;
            dir_x_nxt     = 1'b1;
            dir_y_nxt     = 1'b1;
            serve_cnt_nxt = '0;
            point_p1_nxt  = 1'b0;
            point_p2_nxt  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state     <= IDLE;
            bx        <= X_CENTRE;
            by        <= Y_CENTRE;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            serve_cnt <= '0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            vblnk_d   <= 1'b0;
        end else begin
            state     <= state_nxt;
            bx        <= bx_nxt;
            by        <= by_nxt;
            dir_x     <= dir_x_nxt;
            dir_y     <= dir_y_nxt;
            serve_cnt <= serve_cnt_nxt;
            point_p1  <= point_p1_nxt;
            point_p2  <= point_p2_nxt;
            vblnk_d   <= draw_rect_if.vblnk;
        end
    end

    // Overlay decision uses the input-side counters so the painted square
    // lines up with the delayed timing signals.
    assign hpos    = {1'b0, draw_rect_if.hcount};
    assign vpos    = {1'b0, draw_rect_if.vcount};
    assign in_ball = ball_active &&
                     hpos >= bx && hpos < bx + BALL_SIZE &&
                     vpos >= by && vpos < by + BALL_SIZE;

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            draw_ball_if.vcount <= '0;
            draw_ball_if.vsync  <= 1'b0;
            draw_ball_if.vblnk  <= 1'b0;
            draw_ball_if.hcount <= '0;
            draw_ball_if.hsync  <= 1'b0;
            draw_ball_if.hblnk  <= 1'b0;
            draw_ball_if.rgb    <= '0;
        end else begin
            draw_ball_if.vcount <= draw_rect_if.vcount;
            draw_ball_if.vsync  <= draw_rect_if.vsync;
            draw_ball_if.vblnk  <= draw_rect_if.vblnk;
            draw_ball_if.hcount <= draw_rect_if.hcount;
            draw_ball_if.hsync  <= draw_rect_if.hsync;
            draw_ball_if.hblnk  <= draw_rect_if.hblnk;
            draw_ball_if.rgb    <= in_ball ? BALL_RGB : draw_rect_if.rgb;
        end
    end

endmodule
